fft16_input_sched: RTL and testbench

FFT16_INPUT_SCHED -- requirements
Module: fft16_input_sched

---
 rtl/fft16_input_sched.sv | 95 +++++++++
 tb/tb_fft16_input_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fft16_input_sched.sv
// fft16_input_sched: collects 16-sample frames and presents them as radix-4 groups {g, g+4, g+8, g+12}.
// Define FFT_SCHED_PINGPONG_EN for a second bank so the next frame fills while the current one drains.
module fft16_input_sched #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out0,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3,
  output logic [1:0]   grp,
  output logic [4:0]   level,
  output logic         frame_done
);

  logic [N-1:0] bank [2][16];
  logic [3:0]   wcnt;
  logic [1:0]   g;
  logic         wb;
  logic         rb;
  logic [1:0]   full;
  logic         wr_en;
  logic         rd_en;
  logic         fill_done;
  logic         drain_done;

  assign in_ready   = ~full[wb];
  assign out_valid  = full[rb];
  assign wr_en      = in_valid & in_ready;
  assign rd_en      = out_valid & out_ready;
  assign fill_done  = wr_en & (wcnt == 4'd15);
  assign drain_done = rd_en & (g == 2'd3);
  assign level      = full[wb] ? 5'd16 : {1'b0, wcnt};

  // Storage is deliberately left unreset; the full flags guard every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[wb][wcnt] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt       <= 4'd0;
      g          <= 2'd0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      full       <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_done;
      if (wr_en) begin
        wcnt <= wcnt + 4'd1;
      end
      if (rd_en) begin
        g <= g + 2'd1;
      end
      // Fill and drain completing together always touch different banks.
      if (drain_done) begin
        full[rb] <= 1'b0;
`ifdef FFT_SCHED_PINGPONG_EN
        rb <= ~rb;
`endif
      end
      if (fill_done) begin
        full[wb] <= 1'b1;
`ifdef FFT_SCHED_PINGPONG_EN
        wb <= ~wb;
`endif
      end
    end
  end

  always_comb begin
    out0 = '0;
    out1 = '0;
    out2 = '0;
    out3 = '0;
    grp  = 2'd0;
    if (out_valid) begin
      out0 = bank[rb][{2'b00, g}];
      out1 = bank[rb][{2'b01, g}];
      out2 = bank[rb][{2'b10, g}];
      out3 = bank[rb][{2'b11, g}];
      grp  = g;
    end
  end

endmodule

// File: tb/tb_fft16_input_sched.sv
// Directed bench for fft16_input_sched: reset, group ordering, stalls, gapped input, full-bank backpressure, mid-frame reset.
module tb_fft16_input_sched;

  localparam int N = 16;
`ifdef FFT_SCHED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out0, out1, out2, out3;
  logic [1:0]   grp;
  logic [4:0]   level;
  logic         frame_done;

  int compared   = 0;
  int mismatched = 0;

  fft16_input_sched #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .grp        (grp),
    .level      (level),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic chk_group(input string tag, input int gi, input int base);
    chk($sformatf("%s_vld%0d", tag, gi), {31'd0, out_valid}, 32'd1);
    chk($sformatf("%s_grp%0d", tag, gi), {30'd0, grp}, gi);
    chk($sformatf("%s_out0_g%0d", tag, gi), {16'd0, out0}, base + gi);
    chk($sformatf("%s_out1_g%0d", tag, gi), {16'd0, out1}, base + gi + 4);
    chk($sformatf("%s_out2_g%0d", tag, gi), {16'd0, out2}, base + gi + 8);
    chk($sformatf("%s_out3_g%0d", tag, gi), {16'd0, out3}, base + gi + 12);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_grp", {30'd0, grp}, 32'd0);
    chk("rst_out0", {16'd0, out0}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // Back-to-back frame, consumer always ready
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = N'(k);
      chk($sformatf("b2b_level%0d", k), {27'd0, level}, k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_in_ready_drain", {31'd0, in_ready}, PP ? 32'd1 : 32'd0);
    chk("b2b_level_drain", {27'd0, level}, PP ? 32'd0 : 32'd16);
    for (int gi = 0; gi < 4; gi++) begin
      chk_group("b2b", gi, 0);
      chk($sformatf("b2b_fd_early%0d", gi), {31'd0, frame_done}, 32'd0);
      @(negedge clk);
    end
    chk("b2b_frame_done", {31'd0, frame_done}, 32'd1);
    chk("b2b_vld_after", {31'd0, out_valid}, 32'd0);
    chk("b2b_out0_after", {16'd0, out0}, 32'd0);
    chk("b2b_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("b2b_level_after", {27'd0, level}, 32'd0);
    @(negedge clk);
    chk("b2b_frame_done_pulse", {31'd0, frame_done}, 32'd0);

    // Gapped input, then a 5-cycle stall while grp=1
    out_ready = 1'b0;
    for (int c = 0; c < 32; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 0) ? N'(100 + c / 2) : 16'hdead;
      chk($sformatf("gap_level_c%0d", c), {27'd0, level},
          (c == 31 && PP) ? 32'd0 : 32'((c + 1) / 2));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk_group("gap", 0, 100);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_group($sformatf("stall%0d", i), 1, 100);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_group("stall_rel", 1, 100);
    @(negedge clk);
    chk_group("gap", 2, 100);
    @(negedge clk);
    chk_group("gap", 3, 100);
    @(negedge clk);
    chk("gap_frame_done", {31'd0, frame_done}, 32'd1);

    // Backpressure when the bank(s) are full
    out_ready = 1'b0;
`ifdef FFT_SCHED_PINGPONG_EN
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = N'(200 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_level_full", {27'd0, level}, 32'd16);
    out_ready = 1'b1;
    for (int gi = 0; gi < 4; gi++) begin
      chk_group("bp_f1", gi, 200);
      @(negedge clk);
    end
    for (int gi = 0; gi < 4; gi++) begin
      chk_group("bp_f2", gi, 216);
      chk($sformatf("bp_f2_fd%0d", gi), {31'd0, frame_done}, (gi == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("bp_frame_done", {31'd0, frame_done}, 32'd1);
    chk("bp_vld_after", {31'd0, out_valid}, 32'd0);
`else
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = N'(200 + k);
      @(negedge clk);
    end
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_level_full", {27'd0, level}, 32'd16);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = N'(300 + i);
      chk($sformatf("bp_hold_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int gi = 0; gi < 4; gi++) begin
      in_valid = 1'b1;
      in_data  = N'(310 + gi);
      chk_group("bp", gi, 200);
      chk($sformatf("bp_drain_in_ready%0d", gi), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_frame_done", {31'd0, frame_done}, 32'd1);
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_level_after", {27'd0, level}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
`endif

    // Reset mid-frame discards partial data
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = N'(400 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_level7", {27'd0, level}, 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = N'(500 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int gi = 0; gi < 4; gi++) begin
      chk_group("mid", gi, 500);
      @(negedge clk);
    end
    chk("mid_frame_done", {31'd0, frame_done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
